// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: bus writes are queued in a small FIFO and folded into
// the CRC one byte per clock, most-significant byte first, with no bit reflection.
module crc_stream_engine #(
  parameter int          CRC_W      = 32,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] POLY_DEF   = 32'h04C11DB7,
  parameter logic [31:0] INIT_DEF   = 32'hFFFFFFFF,
  parameter logic [31:0] XOR_DEF    = 32'h00000000,
  parameter logic [7:0]  CONF_ADR   = 8'h10,
  parameter logic [7:0]  DATA_ADR   = 8'h11,
  parameter logic [7:0]  OUT_ADR    = 8'h12,
  parameter logic [7:0]  COUNT_ADR  = 8'h13,
  parameter logic [7:0]  POLY_ADR   = 8'h14,
  parameter logic [7:0]  INIT_ADR   = 8'h15,
  parameter logic [7:0]  XOR_ADR    = 8'h16,
  parameter logic [7:0]  STAT_ADR   = 8'h17
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  pr_adr_i,
  input  logic        edwr_l_i,
  input  logic        edwr_h_i,
  input  logic        sedrd_i,
  input  logic [31:0] src_i,
  output logic [31:0] pr_src_o,
  output logic        irq_o
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;

  logic [31:0]      fifoData_q [FIFO_DEPTH];
  logic             fifoFour_q [FIFO_DEPTH];
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [AW:0]      level_q;
  logic [31:0]      shift_q;
  logic [2:0]       remain_q;
  logic [CRC_W-1:0] crc_q, poly_q, init_q, xor_q;
  logic [31:0]      count_q, rdata_q;
  logic             irqEn_q, irq_q, ovf_q, err_q;

  logic        anyWr, confWr, confInit, dataWr, dataFour, polyWr, initWr, xorWr;
  logic        empty, full, busy, pop, push, byteEn, finish;
  logic [31:0] pushData, rdVal;

  function automatic logic [CRC_W-1:0] mergeHalf(input logic [CRC_W-1:0] old,
                                                 input logic [31:0] src,
                                                 input logic wrL, input logic wrH);
    logic [31:0] ext;
    ext = 32'(old);
    if (!wrL) ext[15:0] = src[15:0];
    if (!wrH) ext[31:16] = src[31:16];
    return ext[CRC_W-1:0];
  endfunction

  function automatic logic [CRC_W-1:0] crcByte(input logic [CRC_W-1:0] crc,
                                               input logic [7:0] b,
                                               input logic [CRC_W-1:0] poly);
    logic [CRC_W-1:0] c;
    c = crc;
    c[CRC_W-1 -: 8] = c[CRC_W-1 -: 8] ^ b;
    for (int i = 0; i < 8; i++) c = c[CRC_W-1] ? ((c << 1) ^ poly) : (c << 1);
    return c;
  endfunction

  assign anyWr    = !edwr_l_i || !edwr_h_i;
  assign confWr   = (pr_adr_i == CONF_ADR) && !edwr_l_i;
  assign confInit = confWr && src_i[0];
  assign dataWr   = (pr_adr_i == DATA_ADR) && anyWr;
  assign polyWr   = (pr_adr_i == POLY_ADR) && anyWr;
  assign initWr   = (pr_adr_i == INIT_ADR) && anyWr;
  assign xorWr    = (pr_adr_i == XOR_ADR) && anyWr;
  assign dataFour = !edwr_l_i && !edwr_h_i;
  assign pushData = dataFour ? src_i :
                    (!edwr_l_i ? {src_i[15:0], 16'h0} : {src_i[31:16], 16'h0});

  assign empty = (level_q == '0);
  assign full  = (level_q == (AW+1)'(FIFO_DEPTH));
  assign busy  = (state_q != IDLE) || !empty;
  // A full FIFO still accepts a push on the edge that pops it.
  assign push  = dataWr && (!full || pop);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    byteEn  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        byteEn = 1'b1;
        if (remain_q == 3'd1) begin
          if (!empty) begin
            pop = 1'b1;
          end else begin
            state_d = IDLE;
            finish  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (confInit) begin
      state_d = IDLE;
      pop     = 1'b0;
      byteEn  = 1'b0;
      finish  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      level_q  <= '0;
      shift_q  <= '0;
      remain_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifoData_q[i] <= '0;
        fifoFour_q[i] <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      if (confInit) begin
        wrPtr_q <= '0;
        rdPtr_q <= '0;
        level_q <= '0;
      end else begin
        if (push) begin
          fifoData_q[wrPtr_q] <= pushData;
          fifoFour_q[wrPtr_q] <= dataFour;
          wrPtr_q             <= wrPtr_q + 1'b1;
        end
        if (pop) begin
          shift_q  <= fifoData_q[rdPtr_q];
          remain_q <= fifoFour_q[rdPtr_q] ? 3'd4 : 3'd2;
          rdPtr_q  <= rdPtr_q + 1'b1;
        end else if (byteEn) begin
          shift_q  <= shift_q << 8;
          remain_q <= remain_q - 3'd1;
        end
        if (push && !pop)      level_q <= level_q + 1'b1;
        else if (pop && !push) level_q <= level_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      crc_q   <= INIT_DEF[CRC_W-1:0];
      poly_q  <= POLY_DEF[CRC_W-1:0];
      init_q  <= INIT_DEF[CRC_W-1:0];
      xor_q   <= XOR_DEF[CRC_W-1:0];
      count_q <= '0;
      rdata_q <= '0;
      irqEn_q <= 1'b0;
      irq_q   <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (polyWr) begin
        if (busy) err_q <= 1'b1;
        else      poly_q <= mergeHalf(poly_q, src_i, edwr_l_i, edwr_h_i);
      end
      if (initWr) begin
        if (busy) err_q <= 1'b1;
        else      init_q <= mergeHalf(init_q, src_i, edwr_l_i, edwr_h_i);
      end
      if (xorWr) xor_q <= mergeHalf(xor_q, src_i, edwr_l_i, edwr_h_i);
      if (confInit)    crc_q <= init_q;
      else if (byteEn) crc_q <= crcByte(crc_q, shift_q[31:24], poly_q);
      if (confWr && src_i[1]) count_q <= '0;
      else if (byteEn)        count_q <= count_q + 32'd1;
      if (dataWr && full && !pop) ovf_q <= 1'b1;
      if (finish && irqEn_q) irq_q <= 1'b1;
      // Clearing the flags takes priority over anything raised on the same edge.
      if (confWr) begin
        irqEn_q <= src_i[2];
        if (src_i[3]) begin
          ovf_q <= 1'b0;
          err_q <= 1'b0;
          irq_q <= 1'b0;
        end
      end
      if (!sedrd_i) rdata_q <= rdVal;
    end
  end

  always_comb begin
    rdVal = '0;
    case (pr_adr_i)
      OUT_ADR:   rdVal = 32'(crc_q ^ xor_q);
      COUNT_ADR: rdVal = count_q;
      POLY_ADR:  rdVal = 32'(poly_q);
      INIT_ADR:  rdVal = 32'(init_q);
      XOR_ADR:   rdVal = 32'(xor_q);
      STAT_ADR:  rdVal = {16'h0, 8'(level_q), 3'b000, err_q, ovf_q, empty, full, busy};
      default:   rdVal = '0;
    endcase
  end

  assign pr_src_o = rdata_q;
  assign irq_o    = irq_q;
endmodule

// File: tb/tb_crc_stream_engine.sv
// Self-checking bench: a 32-bit and a 16-bit engine share one bus and are
// compared against a byte-queue CRC model, fixed vectors and corner sequences.
module tb_crc_stream_engine;
  localparam logic [7:0] CONF = 8'h10, DATA = 8'h11, OUTR = 8'h12, CNT = 8'h13;
  localparam logic [7:0] POLY = 8'h14, INIT = 8'h15, XORR = 8'h16, STAT = 8'h17;

  logic        clock = 1'b0;
  logic        rst_i;
  logic [7:0]  adr;
  logic        edwrL, edwrH, sedrd;
  logic [31:0] src;
  logic [31:0] rdA, rdB;
  logic        irqA, irqB;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  modelBytes [$];

  always #5 clock = ~clock;

  crc_stream_engine dutA (
    .clk_i(clock), .rst_i(rst_i), .pr_adr_i(adr), .edwr_l_i(edwrL), .edwr_h_i(edwrH),
    .sedrd_i(sedrd), .src_i(src), .pr_src_o(rdA), .irq_o(irqA));

  crc_stream_engine #(.CRC_W(16)) dutB (
    .clk_i(clock), .rst_i(rst_i), .pr_adr_i(adr), .edwr_l_i(edwrL), .edwr_h_i(edwrH),
    .sedrd_i(sedrd), .src_i(src), .pr_src_o(rdB), .irq_o(irqB));

  typedef struct {
    logic [31:0] xorv;
    logic [31:0] init;
    logic [31:0] data;
    logic        l;
    logic        h;
    logic [31:0] expOut;
    logic [31:0] expCount;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus write sampled at the next rising edge; l/h are active-low strobes.
  task automatic applyStimulus(input logic [7:0] a, input logic [31:0] d,
                               input logic l, input logic h);
    @(negedge clock);
    adr = a; src = d; edwrL = l; edwrH = h;
    @(posedge clock);
    #1;
    edwrL = 1'b1; edwrH = 1'b1;
  endtask

  task automatic busRead(input logic [7:0] a, output logic [31:0] va, output logic [31:0] vb);
    @(negedge clock);
    adr = a; sedrd = 1'b0;
    @(posedge clock);
    #1;
    sedrd = 1'b1;
    va = rdA; vb = rdB;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clock);
  endtask

  task automatic waitIdle();
    logic [31:0] a, b;
    bit done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      busRead(STAT, a, b);
      if (!a[0] && !b[0]) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL waitIdle: busy still %b/%b after 100 reads, required 0", a[0], b[0]);
    end
  endtask

  task automatic modelPush(input logic [31:0] d, input logic l, input logic h);
    if (!l && !h) begin
      modelBytes.push_back(d[31:24]); modelBytes.push_back(d[23:16]);
      modelBytes.push_back(d[15:8]);  modelBytes.push_back(d[7:0]);
    end else if (!l) begin
      modelBytes.push_back(d[15:8]);  modelBytes.push_back(d[7:0]);
    end else begin
      modelBytes.push_back(d[31:24]); modelBytes.push_back(d[23:16]);
    end
  endtask

  // CRC over every queued byte: xor into the top byte, then 8 MSB-first steps.
  function automatic logic [31:0] refCrc(input int w, input logic [31:0] poly, input logic [31:0] init);
    logic [31:0] mask, c, p;
    logic top;
    mask = (w == 32) ? 32'hFFFFFFFF : ((32'h1 << w) - 32'h1);
    c = init & mask;
    p = poly & mask;
    foreach (modelBytes[i]) begin
      c = c ^ (32'(modelBytes[i]) << (w - 8));
      for (int k = 0; k < 8; k++) begin
        top = c[w-1];
        c = (c << 1) & mask;
        if (top) c = c ^ p;
      end
    end
    return c;
  endfunction

  initial begin
    vec_t vecs [8];
    logic [31:0] a, b, pv, iv, xv, d;
    logic l, h;
    int n, len;

    vecs[0] = '{32'h0,        32'h0,        32'h00000001, 1'b0, 1'b0, 32'h04C11DB7, 32'd4};
    vecs[1] = '{32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000000, 32'd4};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd4};
    vecs[3] = '{32'h0,        32'h0,        32'hABCD0001, 1'b0, 1'b1, 32'h04C11DB7, 32'd2};
    vecs[4] = '{32'h0,        32'h0,        32'h0001ABCD, 1'b1, 1'b0, 32'h04C11DB7, 32'd2};
    vecs[5] = '{32'h0,        32'h12345678, 32'h12345678, 1'b0, 1'b0, 32'h00000000, 32'd4};
    vecs[6] = '{32'h0,        32'hABCDEF01, 32'h1234ABCD, 1'b0, 1'b1, 32'hEF010000, 32'd2};
    vecs[7] = '{32'h0000FFFF, 32'h0,        32'h00000000, 1'b0, 1'b0, 32'h0000FFFF, 32'd4};

    rst_i = 1'b0; adr = 8'h00; src = '0; edwrL = 1'b1; edwrH = 1'b1; sedrd = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("reset pr_src_o A", rdA, 32'h0);
    checkOutput("reset irq_o A", 32'(irqA), 32'h0);
    rst_i = 1'b1;

    busRead(STAT, a, b);
    checkOutput("reset STAT A", a, 32'h4);
    checkOutput("reset STAT B", b, 32'h4);
    busRead(CNT, a, b);  checkOutput("reset COUNT A", a, 32'h0);
    busRead(POLY, a, b); checkOutput("reset POLY A", a, 32'h04C11DB7);
    checkOutput("reset POLY B", b, 32'h00001DB7);
    busRead(INIT, a, b); checkOutput("reset INIT B", b, 32'h0000FFFF);
    busRead(OUTR, a, b); checkOutput("reset OUT A", a, 32'hFFFFFFFF);
    busRead(8'h00, a, b); checkOutput("read addr 0", a, 32'h0);

    foreach (vecs[i]) begin
      applyStimulus(XORR, vecs[i].xorv, 1'b0, 1'b0);
      applyStimulus(INIT, vecs[i].init, 1'b0, 1'b0);
      applyStimulus(CONF, 32'h3, 1'b0, 1'b0);
      applyStimulus(DATA, vecs[i].data, vecs[i].l, vecs[i].h);
      waitIdle();
      busRead(OUTR, a, b); checkOutput($sformatf("vec%0d OUT", i), a, vecs[i].expOut);
      busRead(CNT, a, b);  checkOutput($sformatf("vec%0d COUNT", i), a, vecs[i].expCount);
      checkOutput($sformatf("vec%0d irq", i), 32'(irqA), 32'h0);
    end

    applyStimulus(XORR, 32'h0, 1'b0, 1'b0);
    applyStimulus(INIT, 32'h0, 1'b0, 1'b0);
    applyStimulus(CONF, 32'h7, 1'b0, 1'b0);
    checkOutput("irq before push", 32'(irqA), 32'h0);
    applyStimulus(DATA, 32'h55AA0001, 1'b0, 1'b1);
    waitIdle();
    checkOutput("irq A set", 32'(irqA), 32'h1);
    checkOutput("irq B set", 32'(irqB), 32'h1);
    busRead(OUTR, a, b);
    checkOutput("irq OUT A", a, 32'h04C11DB7);
    checkOutput("irq OUT B", b, 32'h00001DB7);
    busRead(CNT, a, b); checkOutput("irq COUNT", a, 32'd2);
    applyStimulus(CONF, 32'h8, 1'b0, 1'b0);
    checkOutput("irq cleared", 32'(irqA), 32'h0);

    modelBytes.delete();
    applyStimulus(CONF, 32'hB, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      d = $urandom;
      if (i < 6) modelPush(d, 1'b0, 1'b0);
      applyStimulus(DATA, d, 1'b0, 1'b0);
    end
    idleCycles(18);
    busRead(STAT, a, b); checkOutput("ovf STAT last byte", a, 32'h0D);
    busRead(STAT, a, b); checkOutput("ovf STAT A idle", a, 32'h0C);
    checkOutput("ovf STAT B idle", b, 32'h0C);
    busRead(CNT, a, b);  checkOutput("ovf COUNT", a, 32'd24);
    busRead(OUTR, a, b);
    checkOutput("ovf OUT A", a, refCrc(32, 32'h04C11DB7, 32'h0));
    checkOutput("ovf OUT B", b, refCrc(16, 32'h04C11DB7, 32'h0));

    for (int r = 0; r < 10; r++) begin
      modelBytes.delete();
      pv = $urandom; iv = $urandom; xv = $urandom;
      applyStimulus(POLY, pv, 1'b0, 1'b0);
      applyStimulus(INIT, iv, 1'b0, 1'b0);
      applyStimulus(XORR, xv, 1'b0, 1'b0);
      applyStimulus(CONF, 32'h3, 1'b0, 1'b0);
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        d = $urandom;
        case ($urandom_range(0, 2))
          0:       begin l = 1'b0; h = 1'b0; len = 4; end
          1:       begin l = 1'b0; h = 1'b1; len = 2; end
          default: begin l = 1'b1; h = 1'b0; len = 2; end
        endcase
        modelPush(d, l, h);
        applyStimulus(DATA, d, l, h);
        idleCycles(len - 1 + $urandom_range(0, 2));
      end
      waitIdle();
      busRead(OUTR, a, b);
      checkOutput($sformatf("rnd%0d OUT A", r), a, refCrc(32, pv, iv) ^ xv);
      checkOutput($sformatf("rnd%0d OUT B", r), b, (refCrc(16, pv, iv) ^ xv) & 32'hFFFF);
      busRead(CNT, a, b);
      checkOutput($sformatf("rnd%0d COUNT A", r), a, 32'(modelBytes.size()));
      checkOutput($sformatf("rnd%0d COUNT B", r), b, 32'(modelBytes.size()));
    end

    applyStimulus(POLY, 32'h00001021, 1'b0, 1'b0);
    applyStimulus(INIT, 32'h0, 1'b0, 1'b0);
    applyStimulus(XORR, 32'h0, 1'b0, 1'b0);
    applyStimulus(CONF, 32'hB, 1'b0, 1'b0);
    applyStimulus(DATA, 32'h00000001, 1'b0, 1'b0);
    waitIdle();
    busRead(OUTR, a, b);
    checkOutput("crc16 OUT B", b, 32'h00001021);
    checkOutput("crc16 OUT A", a, 32'h00001021);
    applyStimulus(DATA, 32'h00000001, 1'b0, 1'b0);
    applyStimulus(POLY, 32'hFFFFFFFF, 1'b0, 1'b0);
    waitIdle();
    busRead(POLY, a, b);
    checkOutput("busy POLY A kept", a, 32'h00001021);
    checkOutput("busy POLY B kept", b, 32'h00001021);
    busRead(STAT, a, b); checkOutput("busy STAT err B", b, 32'h14);
    applyStimulus(POLY, 32'hABCD5555, 1'b1, 1'b0);
    busRead(POLY, a, b);
    checkOutput("half POLY A", a, 32'hABCD1021);
    checkOutput("half POLY B", b, 32'h00001021);
    applyStimulus(XORR, 32'hFFFF1234, 1'b0, 1'b1);
    busRead(XORR, a, b); checkOutput("half XOR A", a, 32'h00001234);
    applyStimulus(CONF, 32'h8, 1'b0, 1'b0);
    busRead(STAT, a, b); checkOutput("err cleared B", b, 32'h4);

    busRead(POLY, a, b);
    applyStimulus(DATA, 32'hDEADBEEF, 1'b0, 1'b0);
    idleCycles(2);
    #3 rst_i = 1'b0;
    #1;
    checkOutput("midreset pr_src_o", rdA, 32'h0);
    checkOutput("midreset irq_o", 32'(irqA), 32'h0);
    @(negedge clock);
    rst_i = 1'b1;
    busRead(STAT, a, b);
    checkOutput("post-reset STAT A", a, 32'h4);
    checkOutput("post-reset STAT B", b, 32'h4);
    busRead(CNT, a, b);  checkOutput("post-reset COUNT", a, 32'h0);
    busRead(POLY, a, b);
    checkOutput("post-reset POLY A", a, 32'h04C11DB7);
    checkOutput("post-reset POLY B", b, 32'h00001DB7);
    busRead(XORR, a, b); checkOutput("post-reset XOR A", a, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end
endmodule
